spr_hshrink_xgen: RTL and testbench

//  Sprite horizontal render stage, downstream of the fast-cycle sync block.

---
 rtl/spr_hshrink_xgen.sv | 172 +++++++++++++++++
 tb/tb_spr_hshrink_xgen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spr_hshrink_xgen.sv
// spr_hshrink_xgen -- sprite horizontal render stage.
//
// Takes one 14-bit parameter word per sprite tile {CHAIN, HSHRINK[3:0], XPOS[8:0]},
// walks the 16 tile columns on successive PIX_EN strobes, drops columns according
// to the 16-column H-shrink mask, and emits line-buffer write strobes/addresses
// together with the tile column index used by the graphics fetch.
//
// Ports:
//   CLK       single system clock, rising edge
//   RESET     asynchronous, active-high reset
//   PIX_EN    pixel-step enable, 1 CLK wide
//   NEW_LINE  line-start strobe: clears chain state, aborts any run
//   LOAD      parameter strobe, PIPE_C valid on this cycle
//   PIPE_C    {CHAIN[13], HSHRINK[12:9], XPOS[8:0]}
//   FLIP      horizontal flip (tile column order reversed)
//   LB_WE     line-buffer write strobe (registered, 1 CLK wide)
//   LB_ADDR   line-buffer X address for LB_WE (holds between writes)
//   PIX_COL   tile column 0..15 of the current write (holds between writes)
//   BUSY      high while a tile is being stepped
//   DONE      1-CLK pulse with the 16th column step
//
// Build option: define SPR_CLIP_EN to suppress writes at X >= LB_WIDTH.
// Without it every kept column writes and LB_WIDTH is ignored.

module spr_hshrink_xgen #(
  parameter int LB_WIDTH = 320
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIX_EN,
  input  logic        NEW_LINE,
  input  logic        LOAD,
  input  logic [13:0] PIPE_C,
  input  logic        FLIP,
  output logic        LB_WE,
  output logic [8:0]  LB_ADDR,
  output logic [3:0]  PIX_COL,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  // Shrink pattern for HSHRINK h; bit 15 is the first step, popcount = h+1.
  function automatic logic [15:0] shrink_mask(input logic [3:0] h);
    case (h)
      4'd0:    shrink_mask = 16'h0080;
      4'd1:    shrink_mask = 16'h0880;
      4'd2:    shrink_mask = 16'h08A0;
      4'd3:    shrink_mask = 16'h28A0;
      4'd4:    shrink_mask = 16'h2AA0;
      4'd5:    shrink_mask = 16'hAAA0;
      4'd6:    shrink_mask = 16'hAAA2;
      4'd7:    shrink_mask = 16'hAAAA;
      4'd8:    shrink_mask = 16'hAEAA;
      4'd9:    shrink_mask = 16'hEEAA;
      4'd10:   shrink_mask = 16'hEEAE;
      4'd11:   shrink_mask = 16'hEEEE;
      4'd12:   shrink_mask = 16'hEFEE;
      4'd13:   shrink_mask = 16'hFFEE;
      4'd14:   shrink_mask = 16'hFFEF;
      default: shrink_mask = 16'hFFFF;
    endcase
  endfunction

  logic        state;
  logic [3:0]  step;
  logic [8:0]  x;
  logic [15:0] mask;
  logic [8:0]  prev_x;
  logic [4:0]  prev_w;

  logic [8:0]  base_x;
  logic [4:0]  base_w;
  logic [8:0]  start_x;
  logic [3:0]  col;
  logic        keep;
  logic        write_ok;

  // Chain base, start X, column index and keep decision for the current step.
  always_comb begin
    // NEW_LINE on the same cycle as LOAD clears the chain base first.
    if (NEW_LINE) begin
      base_x = 9'd0;
      base_w = 5'd0;
    end else begin
      base_x = prev_x;
      base_w = prev_w;
    end
    if (PIPE_C[13]) begin
      start_x = base_x + {4'd0, base_w};
    end else begin
      start_x = PIPE_C[8:0];
    end
    // The shrink mask is applied in screen (step) order; FLIP only reverses
    // which tile column is fetched at each screen position.
    keep = mask[4'd15 - step];
    if (FLIP) begin
      col = 4'd15 - step;
    end else begin
      col = step;
    end
  end

`ifdef SPR_CLIP_EN
  localparam logic [9:0] LB_LIMIT = 10'(LB_WIDTH);

  // Off-screen kept columns still advance X but do not strobe.
  always_comb begin
    if ({1'b0, x} < LB_LIMIT) begin
      write_ok = 1'b1;
    end else begin
      write_ok = 1'b0;
    end
  end
`else
  logic unused_lb_width;
  assign unused_lb_width = ^LB_WIDTH;
  assign write_ok = 1'b1;
`endif

  // Tile stepping state, chain memory and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      step    <= 4'd0;
      x       <= 9'd0;
      mask    <= 16'h0000;
      prev_x  <= 9'd0;
      prev_w  <= 5'd0;
      LB_WE   <= 1'b0;
      LB_ADDR <= 9'd0;
      PIX_COL <= 4'd0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      LB_WE <= 1'b0;
      DONE  <= 1'b0;
      if (NEW_LINE) begin
        prev_x <= 9'd0;
        prev_w <= 5'd0;
        state  <= IDLE;
        BUSY   <= 1'b0;
      end
      if (LOAD) begin
        // A LOAD always wins: it aborts any run and ignores a coincident PIX_EN.
        prev_x <= start_x;
        prev_w <= {1'b0, PIPE_C[12:9]} + 5'd1;
        x      <= start_x;
        step   <= 4'd0;
        mask   <= shrink_mask(PIPE_C[12:9]);
        state  <= RUN;
        BUSY   <= 1'b1;
      end else if (!NEW_LINE && state == RUN && PIX_EN) begin
        if (keep) begin
          LB_WE   <= write_ok;
          LB_ADDR <= x;
          PIX_COL <= col;
          x       <= x + 9'd1;
        end
        step <= step + 4'd1;
        if (step == 4'd15) begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spr_hshrink_xgen.sv
module tb_spr_hshrink_xgen;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PIX_EN;
  logic        NEW_LINE;
  logic        LOAD;
  logic [13:0] PIPE_C;
  logic        FLIP;
  logic        LB_WE;
  logic [8:0]  LB_ADDR;
  logic [3:0]  PIX_COL;
  logic        BUSY;
  logic        DONE;

  int vec  = 0;
  int miss = 0;

  logic [8:0] wa[$];
  logic [3:0] wc[$];
  int dcnt, dstep, stray;

  spr_hshrink_xgen #(.LB_WIDTH(320)) dut (
    .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN), .NEW_LINE(NEW_LINE),
    .LOAD(LOAD), .PIPE_C(PIPE_C), .FLIP(FLIP), .LB_WE(LB_WE),
    .LB_ADDR(LB_ADDR), .PIX_COL(PIX_COL), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic load_tile(input logic chain, input logic [3:0] h, input logic [8:0] xp,
                           input logic flip_v, input logic with_pix, input logic with_nl);
    FLIP = flip_v;
    PIPE_C = {chain, h, xp};
    LOAD = 1'b1;
    PIX_EN = with_pix;
    NEW_LINE = with_nl;
    @(posedge CLK); #1;
    LOAD = 1'b0;
    PIX_EN = 1'b0;
    NEW_LINE = 1'b0;
  endtask

  // Pulse PIX_EN n times (one idle CLK between) and record writes and DONE.
  task automatic run_steps(input int n);
    wa.delete(); wc.delete();
    dcnt = 0; dstep = 0; stray = 0;
    for (int i = 0; i < n; i++) begin
      PIX_EN = 1'b1;
      @(posedge CLK); #1;
      PIX_EN = 1'b0;
      if (LB_WE) begin wa.push_back(LB_ADDR); wc.push_back(PIX_COL); end
      if (DONE) begin dcnt++; dstep = i + 1; end
      @(posedge CLK); #1;
      if (LB_WE || DONE) stray++;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; PIX_EN = 1'b0; NEW_LINE = 1'b0; LOAD = 1'b0; PIPE_C = 14'd0; FLIP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vec++;
    if ({LB_WE, LB_ADDR, PIX_COL, BUSY, DONE} !== 16'd0) begin
      miss++; $display("FAIL reset_vals got %h want 0", {LB_WE, LB_ADDR, PIX_COL, BUSY, DONE});
    end
    RESET = 1'b0;
    @(posedge CLK); #1;
    vec++;
    if ({LB_WE, LB_ADDR, PIX_COL, BUSY, DONE} !== 16'd0) begin
      miss++; $display("FAIL post_reset got %h want 0", {LB_WE, LB_ADDR, PIX_COL, BUSY, DONE});
    end
  endtask

  task automatic test_full_tile;
    load_tile(1'b0, 4'd15, 9'd10, 1'b0, 1'b0, 1'b0);
    vec++;
    if (BUSY !== 1'b1) begin miss++; $display("FAIL full_busy got %b want 1", BUSY); end
    run_steps(16);
    vec++;
    if (wa.size() != 16) begin miss++; $display("FAIL full_count got %0d want 16", wa.size()); end
    for (int i = 0; i < 16; i++) begin
      vec++;
      if (i >= wa.size()) begin
        miss++; $display("FAIL full_write%0d missing", i);
      end else if (wa[i] !== 9'(10 + i) || wc[i] !== 4'(i)) begin
        miss++; $display("FAIL full_write%0d got addr %0d col %0d want addr %0d col %0d",
                         i, wa[i], wc[i], 10 + i, i);
      end
    end
    vec++;
    if (dcnt != 1 || dstep != 16 || stray != 0) begin
      miss++; $display("FAIL full_done got cnt %0d step %0d stray %0d want 1 16 0", dcnt, dstep, stray);
    end
    vec++;
    if (BUSY !== 1'b0) begin miss++; $display("FAIL full_idle got busy %b want 0", BUSY); end
  endtask

  task automatic test_flip;
    load_tile(1'b0, 4'd0, 9'd50, 1'b0, 1'b0, 1'b0);
    run_steps(16);
    vec++;
    if (wa.size() != 1 || wa[0] !== 9'd50 || wc[0] !== 4'd8) begin
      miss++; $display("FAIL noflip got n %0d addr %0d col %0d want 1 50 8", wa.size(),
                       (wa.size() > 0) ? wa[0] : 9'd0, (wc.size() > 0) ? wc[0] : 4'd0);
    end
    load_tile(1'b0, 4'd0, 9'd50, 1'b1, 1'b0, 1'b0);
    run_steps(16);
    vec++;
    if (wa.size() != 1 || wa[0] !== 9'd50 || wc[0] !== 4'd7) begin
      miss++; $display("FAIL flip got n %0d addr %0d col %0d want 1 50 7", wa.size(),
                       (wa.size() > 0) ? wa[0] : 9'd0, (wc.size() > 0) ? wc[0] : 4'd0);
    end
    FLIP = 1'b0;
  endtask

  task automatic test_chain;
    logic [3:0] ecol [4];
    ecol = '{4'd2, 4'd4, 4'd8, 4'd10};
    load_tile(1'b0, 4'd7, 9'd100, 1'b0, 1'b0, 1'b0);
    run_steps(16);
    vec++;
    if (wa.size() != 8) begin miss++; $display("FAIL chain_first got %0d want 8", wa.size()); end
    load_tile(1'b1, 4'd3, 9'd0, 1'b0, 1'b0, 1'b0);
    run_steps(16);
    vec++;
    if (wa.size() != 4) begin miss++; $display("FAIL chain_count got %0d want 4", wa.size()); end
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (i >= wa.size()) begin
        miss++; $display("FAIL chain_write%0d missing", i);
      end else if (wa[i] !== 9'(108 + i) || wc[i] !== ecol[i]) begin
        miss++; $display("FAIL chain_write%0d got addr %0d col %0d want addr %0d col %0d",
                         i, wa[i], wc[i], 108 + i, ecol[i]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [8:0] eaddr [4];
    logic [3:0] ecol [4];
    int n;
`ifdef SPR_CLIP_EN
    n = 2;
    eaddr = '{9'd0, 9'd1, 9'd0, 9'd0};
    ecol  = '{4'd8, 4'd10, 4'd0, 4'd0};
`else
    n = 4;
    eaddr = '{9'd510, 9'd511, 9'd0, 9'd1};
    ecol  = '{4'd2, 4'd4, 4'd8, 4'd10};
`endif
    load_tile(1'b0, 4'd3, 9'd510, 1'b0, 1'b0, 1'b0);
    run_steps(16);
    vec++;
    if (wa.size() != n) begin miss++; $display("FAIL wrap_count got %0d want %0d", wa.size(), n); end
    for (int i = 0; i < n; i++) begin
      vec++;
      if (i >= wa.size()) begin
        miss++; $display("FAIL wrap_write%0d missing", i);
      end else if (wa[i] !== eaddr[i] || wc[i] !== ecol[i]) begin
        miss++; $display("FAIL wrap_write%0d got addr %0d col %0d want addr %0d col %0d",
                         i, wa[i], wc[i], eaddr[i], ecol[i]);
      end
    end
  endtask

  task automatic test_abort;
    load_tile(1'b0, 4'd15, 9'd20, 1'b0, 1'b0, 1'b0);
    run_steps(5);
    vec++;
    if (wa.size() != 5 || dcnt != 0) begin
      miss++; $display("FAIL abort_pre got n %0d done %0d want 5 0", wa.size(), dcnt);
    end
    load_tile(1'b0, 4'd15, 9'd200, 1'b0, 1'b0, 1'b0);
    vec++;
    if (DONE !== 1'b0 || BUSY !== 1'b1) begin
      miss++; $display("FAIL abort_load got done %b busy %b want 0 1", DONE, BUSY);
    end
    run_steps(16);
    vec++;
    if (wa.size() != 16) begin miss++; $display("FAIL abort_count got %0d want 16", wa.size()); end
    for (int i = 0; i < 16; i++) begin
      vec++;
      if (i >= wa.size()) begin
        miss++; $display("FAIL abort_write%0d missing", i);
      end else if (wa[i] !== 9'(200 + i)) begin
        miss++; $display("FAIL abort_write%0d got addr %0d want %0d", i, wa[i], 200 + i);
      end
    end
    vec++;
    if (dcnt != 1 || dstep != 16) begin
      miss++; $display("FAIL abort_done got cnt %0d step %0d want 1 16", dcnt, dstep);
    end
  endtask

  task automatic test_back_to_back;
    // LOAD with PIX_EN on the same CLK: no step taken on the LOAD cycle.
    load_tile(1'b0, 4'd15, 9'd30, 1'b0, 1'b1, 1'b0);
    vec++;
    if (LB_WE !== 1'b0) begin miss++; $display("FAIL loadpix_we got %b want 0", LB_WE); end
    run_steps(16);
    vec++;
    if (wa.size() != 16 || wa[0] !== 9'd30 || wc[0] !== 4'd0 || dcnt != 1 || dstep != 16) begin
      miss++; $display("FAIL loadpix_run got n %0d first %0d done %0d at %0d want 16 30 1 16",
                       wa.size(), (wa.size() > 0) ? wa[0] : 9'd0, dcnt, dstep);
    end
    // NEW_LINE with a CHAIN LOAD: base cleared first, tile starts at X=0.
    load_tile(1'b1, 4'd0, 9'd77, 1'b0, 1'b0, 1'b1);
    run_steps(16);
    vec++;
    if (wa.size() != 1 || wa[0] !== 9'd0 || wc[0] !== 4'd8) begin
      miss++; $display("FAIL nl_load got n %0d addr %0d want 1 0", wa.size(),
                       (wa.size() > 0) ? wa[0] : 9'd0);
    end
    // NEW_LINE alone mid-run aborts without DONE.
    load_tile(1'b0, 4'd15, 9'd40, 1'b0, 1'b0, 1'b0);
    run_steps(3);
    NEW_LINE = 1'b1;
    @(posedge CLK); #1;
    NEW_LINE = 1'b0;
    vec++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      miss++; $display("FAIL nl_abort got busy %b done %b want 0 0", BUSY, DONE);
    end
    run_steps(13);
    vec++;
    if (wa.size() != 0 || dcnt != 0) begin
      miss++; $display("FAIL nl_idle got n %0d done %0d want 0 0", wa.size(), dcnt);
    end
    load_tile(1'b1, 4'd0, 9'd77, 1'b0, 1'b0, 1'b0);
    run_steps(16);
    vec++;
    if (wa.size() != 1 || wa[0] !== 9'd0) begin
      miss++; $display("FAIL nl_chain got n %0d addr %0d want 1 0", wa.size(),
                       (wa.size() > 0) ? wa[0] : 9'd0);
    end
  endtask

  task automatic test_reset_midrun;
    load_tile(1'b0, 4'd15, 9'd60, 1'b0, 1'b0, 1'b0);
    run_steps(8);
    PIX_EN = 1'b1;
    @(posedge CLK); #1;
    PIX_EN = 1'b0;
    vec++;
    if (LB_WE !== 1'b1 || LB_ADDR !== 9'd68 || BUSY !== 1'b1) begin
      miss++; $display("FAIL rst_pre got we %b addr %0d busy %b want 1 68 1", LB_WE, LB_ADDR, BUSY);
    end
    RESET = 1'b1;
    #1;
    vec++;
    if ({LB_WE, LB_ADDR, PIX_COL, BUSY, DONE} !== 16'd0) begin
      miss++; $display("FAIL rst_async got %h want 0", {LB_WE, LB_ADDR, PIX_COL, BUSY, DONE});
    end
    #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    load_tile(1'b1, 4'd15, 9'd5, 1'b0, 1'b0, 1'b0);
    run_steps(16);
    vec++;
    if (wa.size() != 16 || wa[0] !== 9'd0 || wa[15] !== 9'd15 || dcnt != 1) begin
      miss++; $display("FAIL rst_chain got n %0d first %0d done %0d want 16 0 1", wa.size(),
                       (wa.size() > 0) ? wa[0] : 9'd0, dcnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_tile();
    test_flip();
    test_chain();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
